// File: rtl/time_entry_if.sv
// Keypad-side handshake and BCD result bundle for the manual time-entry sequencer.
// The slave modport is the sequencer; the master modport is the keypad/counter side.
interface time_entry_if;
  logic       en;
  logic [9:0] keypad;
  logic       sharp;
  logic [3:0] hour_ten;
  logic [3:0] hour_one;
  logic [3:0] min_ten;
  logic [3:0] min_one;
  logic [3:0] sec_ten;
  logic [3:0] sec_one;
  logic [1:0] field;
  logic       busy;
  logic       load;
  logic       error;
  logic       abort;

  modport master (
    output en, keypad, sharp,
    input  hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one,
    input  field, busy, load, error, abort
  );

  modport slave (
    input  en, keypad, sharp,
    output hour_ten, hour_one, min_ten, min_one, sec_ten, sec_one,
    output field, busy, load, error, abort
  );
endinterface

// File: rtl/time_entry_ctrl.sv
// Keypad sequencer: shifts BCD digits into HH, MM, SS, range-checks each field on '#',
// and strobes load once a complete valid time has been entered.
module time_entry_ctrl #(
  parameter int TIMEOUT = 5000,
  parameter int TW      = 13
) (
  input  logic         clk,
  input  logic         rst,
  time_entry_if.slave  bus
);

  // Encodings double as the field output code.
  typedef enum logic [1:0] {
    HOUR = 2'd0,
    MIN  = 2'd1,
    SEC  = 2'd2,
    IDLE = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic            busy_reg, busy_next;
  logic [3:0]      digit_reg  [0:5];
  logic [3:0]      digit_next [0:5];
  logic [TW-1:0]   cnt_reg, cnt_next;
  logic [9:0]      key_prev_reg;
  logic            sharp_prev_reg;
  logic            load_reg, load_next;
  logic            error_reg, error_next;
  logic            abort_reg, abort_next;

  logic            key_acc;
  logic            sharp_acc;
  logic [3:0]      pressed_digit;
  logic [2:0]      ten_idx;
  logic [2:0]      one_idx;
  logic [6:0]      field_value;
  logic [6:0]      field_limit;

  // A press counts only on the transition out of all-released, and only if one-hot.
  assign key_acc   = (bus.keypad != 10'd0) && (key_prev_reg == 10'd0) && $onehot(bus.keypad);
  assign sharp_acc = bus.sharp && !sharp_prev_reg;

  always_comb begin
    pressed_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.keypad[i]) pressed_digit = 4'(i);
    end
  end

  assign ten_idx     = {state_reg, 1'b0};
  assign one_idx     = {state_reg, 1'b1};
  assign field_value = 7'(digit_reg[ten_idx]) * 7'd10 + 7'(digit_reg[one_idx]);
  assign field_limit = (state_reg == HOUR) ? 7'd23 : 7'd59;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_next  = 1'b0;
    error_next = 1'b0;
    abort_next = 1'b0;
    for (int i = 0; i < 6; i++) digit_next[i] = digit_reg[i];

    case (state_reg)
      IDLE: begin
        if (bus.en) begin
          state_next = HOUR;
          cnt_next   = '0;
          for (int i = 0; i < 6; i++) digit_next[i] = 4'd0;
        end
      end
      default: begin
        // '#' takes priority over a simultaneous digit, and any event beats timeout.
        if (sharp_acc) begin
          cnt_next = '0;
          if (field_value <= field_limit) begin
            if (state_reg == SEC) begin
              load_next  = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = state_t'(state_reg + 2'd1);
            end
          end else begin
            error_next          = 1'b1;
            digit_next[ten_idx] = 4'd0;
            digit_next[one_idx] = 4'd0;
          end
        end else if (key_acc) begin
          cnt_next            = '0;
          digit_next[ten_idx] = digit_reg[one_idx];
          digit_next[one_idx] = pressed_digit;
        end else if (cnt_reg == TW'(TIMEOUT - 1)) begin
          abort_next = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
          for (int i = 0; i < 6; i++) digit_next[i] = 4'd0;
        end else begin
          cnt_next = cnt_reg + TW'(1);
        end
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      cnt_reg        <= '0;
      key_prev_reg   <= 10'd0;
      sharp_prev_reg <= 1'b0;
      load_reg       <= 1'b0;
      error_reg      <= 1'b0;
      abort_reg      <= 1'b0;
      for (int i = 0; i < 6; i++) digit_reg[i] <= 4'd0;
    end else begin
      state_reg      <= state_next;
      busy_reg       <= busy_next;
      cnt_reg        <= cnt_next;
      key_prev_reg   <= bus.keypad;
      sharp_prev_reg <= bus.sharp;
      load_reg       <= load_next;
      error_reg      <= error_next;
      abort_reg      <= abort_next;
      for (int i = 0; i < 6; i++) digit_reg[i] <= digit_next[i];
    end
  end

  assign bus.hour_ten = digit_reg[0];
  assign bus.hour_one = digit_reg[1];
  assign bus.min_ten  = digit_reg[2];
  assign bus.min_one  = digit_reg[3];
  assign bus.sec_ten  = digit_reg[4];
  assign bus.sec_one  = digit_reg[5];
  assign bus.field    = state_reg;
  assign bus.busy     = busy_reg;
  assign bus.load     = load_reg;
  assign bus.error    = error_reg;
  assign bus.abort    = abort_reg;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed bench for time_entry_ctrl with TIMEOUT = 20; expected values are hand-derived.
module tb_time_entry_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  time_entry_if bus();

  time_entry_ctrl #(.TIMEOUT(20), .TW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] digits();
    return {bus.hour_ten, bus.hour_one, bus.min_ten, bus.min_one, bus.sec_ten, bus.sec_one};
  endfunction

  function automatic logic [2:0] pulses();
    return {bus.load, bus.error, bus.abort};
  endfunction

  task automatic press(input int d);
    bus.keypad = 10'd1 << d;
    tick();
    chk("key_pulses", 32'(pulses()), 32'd0);
    tick(); tick();
    bus.keypad = 10'd0;
    tick(); tick();
  endtask

  task automatic hash(input logic exp_load, input logic exp_err);
    bus.sharp = 1'b1;
    tick();
    chk("hash_pulses", 32'(pulses()), {29'd0, exp_load, exp_err, 1'b0});
    bus.sharp = 1'b0;
    tick();
    chk("pulse_width", 32'(pulses()), 32'd0);
    tick();
  endtask

  task automatic start();
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    chk("start_field", 32'(bus.field), 32'd0);
    chk("start_busy", 32'(bus.busy), 32'd1);
  endtask

  initial begin
    bus.en = 1'b0;
    bus.keypad = 10'd0;
    bus.sharp = 1'b0;

    // Reset values
    tick(); tick();
    rst = 1'b0;
    chk("rst_field", 32'(bus.field), 32'd3);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_digits", 32'(digits()), 32'd0);
    chk("rst_pulses", 32'(pulses()), 32'd0);

    // Keys in IDLE are ignored
    press(4);
    chk("idle_key", 32'(digits()), 32'd0);

    // Normal entry 12:34:56
    start();
    press(1);
    chk("shift_first", 32'(digits()), 32'h010000);
    press(2);
    hash(1'b0, 1'b0);
    chk("adv_min", 32'(bus.field), 32'd1);
    press(3); press(4);
    hash(1'b0, 1'b0);
    chk("adv_sec", 32'(bus.field), 32'd2);
    press(5); press(6);
    hash(1'b1, 1'b0);
    chk("load_digits", 32'(digits()), 32'h123456);
    chk("load_field", 32'(bus.field), 32'd3);
    chk("load_busy", 32'(bus.busy), 32'd0);

    // Range reject on hour 24, then 23 accepted
    start();
    chk("start_clear", 32'(digits()), 32'd0);
    press(2); press(4);
    hash(1'b0, 1'b1);
    chk("rej_digits", 32'(digits()), 32'd0);
    chk("rej_field", 32'(bus.field), 32'd0);
    press(2); press(3);
    hash(1'b0, 1'b0);
    chk("hour23_field", 32'(bus.field), 32'd1);

    // Minute 60 rejected, then overwrite 9,1,5 -> 15
    press(6); press(0);
    hash(1'b0, 1'b1);
    chk("min60_digits", 32'(digits()), 32'h230000);
    press(9); press(1); press(5);
    chk("overwrite", 32'(digits()), 32'h231500);
    hash(1'b0, 1'b0);
    chk("min15_field", 32'(bus.field), 32'd2);

    // Held key gives one digit
    bus.keypad = 10'd1 << 7;
    for (int i = 0; i < 10; i++) tick();
    bus.keypad = 10'd0;
    tick(); tick();
    chk("held_key", 32'(digits()), 32'h231507);

    // Non-one-hot press ignored
    bus.keypad = 10'h003;
    tick(); tick(); tick();
    bus.keypad = 10'd0;
    tick(); tick();
    chk("multi_key", 32'(digits()), 32'h231507);

    // Key and '#' rising together: digit dropped, 07 validated
    bus.keypad = 10'd1 << 5;
    bus.sharp = 1'b1;
    tick();
    chk("simul_load", 32'(pulses()), 32'h4);
    chk("simul_digits", 32'(digits()), 32'h231507);
    chk("simul_field", 32'(bus.field), 32'd3);
    bus.keypad = 10'd0;
    bus.sharp = 1'b0;
    tick(); tick();

    // Timeout with no events: abort at edge N+20
    start();
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("no_abort_yet", 32'(bus.abort), 32'd0);
    end
    tick();
    chk("abort_pulse", 32'(pulses()), 32'h1);
    chk("abort_field", 32'(bus.field), 32'd3);
    chk("abort_busy", 32'(bus.busy), 32'd0);

    // Back-to-back en; a key restarts the timeout and abort clears digits
    start();
    bus.keypad = 10'd1 << 8;
    tick();
    chk("key_before_to", 32'(digits()), 32'h080000);
    bus.keypad = 10'd0;
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("key_reset_cnt", 32'(bus.abort), 32'd0);
    end
    tick();
    chk("abort2_pulse", 32'(bus.abort), 32'd1);
    chk("abort2_digits", 32'(digits()), 32'd0);
    tick();
    chk("abort2_width", 32'(bus.abort), 32'd0);

    // Reset during SEC, with '#' rising at the same edge: no load
    start();
    press(1); press(2); hash(1'b0, 1'b0);
    press(3); press(4); hash(1'b0, 1'b0);
    press(5);
    chk("pre_rst_field", 32'(bus.field), 32'd2);
    rst = 1'b1;
    bus.sharp = 1'b1;
    tick();
    chk("rst_sec_pulses", 32'(pulses()), 32'd0);
    chk("rst_sec_field", 32'(bus.field), 32'd3);
    chk("rst_sec_digits", 32'(digits()), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_pulses", 32'(pulses()), 32'd0);
    chk("post_rst_field", 32'(bus.field), 32'd3);
    bus.sharp = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
